// File: rtl/energy_job_scheduler.sv
// energy_job_scheduler
// Runs one energy_monitor job at a time: config -> spin vector -> weight row
// stream -> energy readback -> result. Weight data bypasses this block; only
// row-group addresses are issued and the memory->monitor handshake is gated
// by a credit count of reads in flight. Also keeps the running minimum energy
// across jobs for the annealing loop.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | ready for a job; latches spin/start/id on the handshake
//   S_CONFIG | offering the start counter to the monitor
//   S_SPIN   | offering the spin vector to the monitor
//   S_STREAM | issuing row reads, forwarding responses as weight beats
//   S_WAIT_E | waiting for the monitor's total energy
//   S_RESULT | presenting the job result until it is taken
module energy_job_scheduler #(
  parameter int DATASPIN         = 256,
  parameter int PARALLELISM      = 4,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter int ID_BIT           = 8,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int SPINIDX_BIT      = $clog2(DATASPIN),
  parameter int ADDR_BIT         = $clog2(DATASPIN / PARALLELISM)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  logic [DATASPIN-1:0]         job_spin_i,
  input  logic [SPINIDX_BIT-1:0]      job_start_i,
  input  logic [ID_BIT-1:0]           job_id_i,
  output logic                        em_config_valid_o,
  input  logic                        em_config_ready_i,
  output logic [SPINIDX_BIT-1:0]      em_config_counter_o,
  output logic                        em_spin_valid_o,
  input  logic                        em_spin_ready_i,
  output logic [DATASPIN-1:0]         em_spin_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [ADDR_BIT-1:0]         mem_req_addr_o,
  input  logic                        mem_rsp_valid_i,
  output logic                        mem_rsp_ready_o,
  output logic                        em_weight_valid_o,
  input  logic                        em_weight_ready_i,
  input  logic                        em_energy_valid_i,
  output logic                        em_energy_ready_o,
  input  logic [ENERGY_TOTAL_BIT-1:0] em_energy_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [ENERGY_TOTAL_BIT-1:0] res_energy_o,
  output logic [ID_BIT-1:0]           res_id_o,
  output logic                        res_new_best_o,
  output logic [ENERGY_TOTAL_BIT-1:0] best_energy_o,
  output logic [ID_BIT-1:0]           best_id_o,
  input  logic                        clear_best_i
);

  localparam int ROWS      = DATASPIN / PARALLELISM;
  localparam int ROW_BIT   = $clog2(ROWS + 1);
  localparam int PAR_SHIFT = $clog2(PARALLELISM);
  localparam int CRED_BIT  = 4;
  localparam logic [CRED_BIT-1:0] CRED_MAX = CRED_BIT'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SPIN,
    S_STREAM,
    S_WAIT_E,
    S_RESULT
  } state_t;

  state_t                      state_q, state_d;
  logic [DATASPIN-1:0]         spin_q, spin_d;
  logic [SPINIDX_BIT-1:0]      start_q, start_d;
  logic [ID_BIT-1:0]           id_q, id_d;
  logic [ADDR_BIT-1:0]         addr_q, addr_d;
  logic [ROW_BIT-1:0]          req_left_q, req_left_d;
  logic [ROW_BIT-1:0]          fwd_left_q, fwd_left_d;
  logic [CRED_BIT-1:0]         cred_q, cred_d;
  logic [ENERGY_TOTAL_BIT-1:0] res_energy_q, res_energy_d;
  logic                        res_new_best_q, res_new_best_d;
  logic [ENERGY_TOTAL_BIT-1:0] best_energy_q, best_energy_d;
  logic [ID_BIT-1:0]           best_id_q, best_id_d;
  logic                        best_valid_q, best_valid_d;

  logic                        in_stream;
  logic                        fwd_open;
  logic                        req_hs;
  logic                        fwd_hs;
  logic                        best_live;
  logic                        new_best;
  logic [ADDR_BIT-1:0]         start_grp;

  // Handshake gating: every valid/ready is forced low while disabled. Responses
  // are only passed through while at least one read is outstanding, so a stray
  // response is neither forwarded nor acknowledged.
  always_comb begin
    in_stream         = en_i && (state_q == S_STREAM);
    fwd_open          = in_stream && (cred_q != '0);
    job_ready_o       = en_i && (state_q == S_IDLE);
    em_config_valid_o = en_i && (state_q == S_CONFIG);
    em_spin_valid_o   = en_i && (state_q == S_SPIN);
    em_energy_ready_o = en_i && (state_q == S_WAIT_E);
    res_valid_o       = en_i && (state_q == S_RESULT);
    mem_req_valid_o   = in_stream && (req_left_q != '0) && (cred_q < CRED_MAX);
    em_weight_valid_o = fwd_open && mem_rsp_valid_i;
    mem_rsp_ready_o   = fwd_open && em_weight_ready_i;
    req_hs            = mem_req_valid_o && mem_req_ready_i;
    fwd_hs            = em_weight_valid_o && em_weight_ready_i;
  end

  // Best-energy compare; a clear in the same cycle makes the incoming energy win.
  always_comb begin
    start_grp = ADDR_BIT'(job_start_i >> PAR_SHIFT);
    best_live = best_valid_q && !clear_best_i;
    new_best  = !best_live || ($signed(em_energy_i) < $signed(best_energy_q));
  end

  // Next-state and datapath updates; nothing moves while en_i is low.
  always_comb begin
    state_d        = state_q;
    spin_d         = spin_q;
    start_d        = start_q;
    id_d           = id_q;
    addr_d         = addr_q;
    req_left_d     = req_left_q;
    fwd_left_d     = fwd_left_q;
    cred_d         = cred_q;
    res_energy_d   = res_energy_q;
    res_new_best_d = res_new_best_q;
    best_energy_d  = best_energy_q;
    best_id_d      = best_id_q;
    best_valid_d   = best_valid_q;

    if (en_i) begin
      if (clear_best_i) begin
        best_valid_d = 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (job_valid_i) begin
            spin_d     = job_spin_i;
            start_d    = {start_grp, {PAR_SHIFT{1'b0}}};
            id_d       = job_id_i;
            addr_d     = start_grp;
            req_left_d = ROW_BIT'(ROWS) - ROW_BIT'(start_grp);
            fwd_left_d = ROW_BIT'(ROWS) - ROW_BIT'(start_grp);
            cred_d     = '0;
            state_d    = S_CONFIG;
          end
        end

        S_CONFIG: begin
          if (em_config_ready_i) begin
            state_d = S_SPIN;
          end
        end

        S_SPIN: begin
          if (em_spin_ready_i) begin
            state_d = S_STREAM;
          end
        end

        S_STREAM: begin
          if (req_hs) begin
            addr_d     = addr_q + ADDR_BIT'(1);
            req_left_d = req_left_q - ROW_BIT'(1);
          end
          if (fwd_hs) begin
            fwd_left_d = fwd_left_q - ROW_BIT'(1);
            if (fwd_left_q == ROW_BIT'(1)) begin
              state_d = S_WAIT_E;
            end
          end
          if (req_hs && !fwd_hs) begin
            cred_d = cred_q + CRED_BIT'(1);
          end else if (fwd_hs && !req_hs) begin
            cred_d = cred_q - CRED_BIT'(1);
          end
        end

        S_WAIT_E: begin
          if (em_energy_valid_i) begin
            res_energy_d   = em_energy_i;
            res_new_best_d = new_best;
            if (new_best) begin
              best_energy_d = em_energy_i;
              best_id_d     = id_q;
              best_valid_d  = 1'b1;
            end
            state_d = S_RESULT;
          end
        end

        S_RESULT: begin
          if (res_ready_i) begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      spin_q         <= '0;
      start_q        <= '0;
      id_q           <= '0;
      addr_q         <= '0;
      req_left_q     <= '0;
      fwd_left_q     <= '0;
      cred_q         <= '0;
      res_energy_q   <= '0;
      res_new_best_q <= 1'b0;
      best_energy_q  <= '0;
      best_id_q      <= '0;
      best_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      spin_q         <= spin_d;
      start_q        <= start_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      req_left_q     <= req_left_d;
      fwd_left_q     <= fwd_left_d;
      cred_q         <= cred_d;
      res_energy_q   <= res_energy_d;
      res_new_best_q <= res_new_best_d;
      best_energy_q  <= best_energy_d;
      best_id_q      <= best_id_d;
      best_valid_q   <= best_valid_d;
    end
  end

  // Data outputs come straight from the registers.
  always_comb begin
    em_config_counter_o = start_q;
    em_spin_o           = spin_q;
    mem_req_addr_o      = addr_q;
    res_energy_o        = res_energy_q;
    res_id_o            = id_q;
    res_new_best_o      = res_new_best_q;
    best_energy_o       = best_energy_q;
    best_id_o           = best_id_q;
  end

endmodule

// File: tb/tb_energy_job_scheduler.sv
// Bench for energy_job_scheduler: memory and monitor models plus a per-cycle
// compare process against a job-level model of the scheduler.
module tb_energy_job_scheduler;

  localparam int DS   = 256;
  localparam int PAR  = 4;
  localparam int EB   = 32;
  localparam int IDB  = 8;
  localparam int MAXO = 4;
  localparam int SB   = 8;
  localparam int AB   = 6;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            en_i = 1'b1;
  logic            job_valid_i = 1'b0;
  logic            job_ready_o;
  logic [DS-1:0]   job_spin_i = '0;
  logic [SB-1:0]   job_start_i = '0;
  logic [IDB-1:0]  job_id_i = '0;
  logic            em_config_valid_o;
  logic            em_config_ready_i = 1'b0;
  logic [SB-1:0]   em_config_counter_o;
  logic            em_spin_valid_o;
  logic            em_spin_ready_i = 1'b0;
  logic [DS-1:0]   em_spin_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i = 1'b0;
  logic [AB-1:0]   mem_req_addr_o;
  logic            mem_rsp_valid_i = 1'b0;
  logic            mem_rsp_ready_o;
  logic            em_weight_valid_o;
  logic            em_weight_ready_i = 1'b0;
  logic            em_energy_valid_i = 1'b0;
  logic            em_energy_ready_o;
  logic [EB-1:0]   em_energy_i = '0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [EB-1:0]   res_energy_o;
  logic [IDB-1:0]  res_id_o;
  logic            res_new_best_o;
  logic [EB-1:0]   best_energy_o;
  logic [IDB-1:0]  best_id_o;
  logic            clear_best_i = 1'b0;

  energy_job_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_spin_i(job_spin_i),
    .job_start_i(job_start_i), .job_id_i(job_id_i),
    .em_config_valid_o(em_config_valid_o), .em_config_ready_i(em_config_ready_i),
    .em_config_counter_o(em_config_counter_o),
    .em_spin_valid_o(em_spin_valid_o), .em_spin_ready_i(em_spin_ready_i), .em_spin_o(em_spin_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .em_weight_valid_o(em_weight_valid_o), .em_weight_ready_i(em_weight_ready_i),
    .em_energy_valid_i(em_energy_valid_i), .em_energy_ready_o(em_energy_ready_o),
    .em_energy_i(em_energy_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_energy_o(res_energy_o),
    .res_id_o(res_id_o), .res_new_best_o(res_new_best_o),
    .best_energy_o(best_energy_o), .best_id_o(best_id_o), .clear_best_i(clear_best_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // environment knobs set by the stimulus process
  int          lat_min = 3, lat_max = 3;
  bit          rnd_ready = 1'b0;
  bit          stray = 1'b0;
  bit          res_hold = 1'b0;
  bit          clear_req = 1'b0;
  bit          clear_on_energy = 1'b0;

  // job-level model
  int          cyc = 0;
  int          q_t[$];
  int          out_m = 0, max_out = 0;
  int          exp_start = 0, exp_rows = 0, exp_addr = 0;
  int          req_left_m = 0, fwd_left_m = 0;
  logic [DS-1:0] exp_spin = '0;
  logic [IDB-1:0] exp_id = '0;
  logic signed [EB-1:0] job_energy = '0;
  bit          streaming_m = 1'b0, energy_pend = 1'b0;
  int          reqs_seen = 0, beats_seen = 0;
  bit          job_done = 1'b0;
  bit          bv_m = 1'b0;
  logic signed [EB-1:0] be_m = '0;
  logic [IDB-1:0] bid_m = '0;
  logic signed [EB-1:0] exp_res_e = '0;
  bit          exp_nb_m = 1'b0;
  bit          last_nb = 1'b0;
  logic [AB-1:0] prev_addr = '0;
  bit          prev_en = 1'b1;

  logic [14:0] others;
  assign others = {em_config_valid_o, em_spin_valid_o, mem_req_valid_o, mem_rsp_ready_o,
                   em_weight_valid_o, em_energy_ready_o, res_valid_o, res_new_best_o,
                   |em_config_counter_o, |em_spin_o, |mem_req_addr_o, |res_energy_o,
                   |res_id_o, |best_energy_o, |best_id_o};

  // Memory + monitor drivers, then compare against the model every cycle.
  always begin
    @(posedge clk_i);
    #1;
    cyc++;
    mem_rsp_valid_i   = stray || (q_t.size() > 0 && q_t[0] <= cyc);
    em_weight_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_req_ready_i   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    em_config_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    em_spin_ready_i   = 1'b1;
    em_energy_valid_i = energy_pend;
    em_energy_i       = job_energy;
    clear_best_i      = clear_req || (clear_on_energy && energy_pend);
    res_ready_i       = !res_hold;
    #1;
    if (!rst_ni) begin
      q_t.delete();
      out_m = 0; streaming_m = 0; energy_pend = 0;
      req_left_m = 0; fwd_left_m = 0;
      bv_m = 0; be_m = '0; bid_m = '0;
    end else if (!en_i) begin
      check(others[14:8] == 7'd0 && !job_ready_o, "frozen_handshakes_low",
            longint'({job_ready_o, others[14:8]}), 0);
      if (!prev_en)
        check(mem_req_addr_o == prev_addr, "frozen_addr", mem_req_addr_o, prev_addr);
    end else begin
      check(out_m <= MAXO, "credits_bound", out_m, MAXO);
      check(mem_req_valid_o == (streaming_m && req_left_m > 0 && out_m < MAXO),
            "req_valid", mem_req_valid_o, (streaming_m && req_left_m > 0 && out_m < MAXO));
      check(em_weight_valid_o == (streaming_m && out_m > 0 && mem_rsp_valid_i),
            "weight_valid", em_weight_valid_o, (streaming_m && out_m > 0 && mem_rsp_valid_i));
      check(mem_rsp_ready_o == (streaming_m && out_m > 0 && em_weight_ready_i),
            "rsp_ready", mem_rsp_ready_o, (streaming_m && out_m > 0 && em_weight_ready_i));

      if (em_config_valid_o && em_config_ready_i)
        check(em_config_counter_o == SB'(exp_start), "config_counter", em_config_counter_o, exp_start);
      if (em_spin_valid_o && em_spin_ready_i) begin
        check(em_spin_o == exp_spin, "spin_vector", longint'(em_spin_o[63:0]), longint'(exp_spin[63:0]));
        streaming_m = 1; req_left_m = exp_rows; fwd_left_m = exp_rows;
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        check(mem_req_addr_o == AB'(exp_addr), "req_addr", mem_req_addr_o, exp_addr);
        check(req_left_m > 0, "extra_request", reqs_seen + 1, exp_rows);
        exp_addr++; req_left_m--; reqs_seen++; out_m++;
        q_t.push_back(cyc + $urandom_range(lat_min, lat_max));
      end
      if (em_weight_valid_o && em_weight_ready_i) begin
        check(fwd_left_m > 0, "extra_beat", beats_seen + 1, exp_rows);
        if (q_t.size() > 0) void'(q_t.pop_front());
        fwd_left_m--; beats_seen++; out_m--;
        if (fwd_left_m == 0) begin
          streaming_m = 0; energy_pend = 1;
        end
      end
      if (out_m > max_out) max_out = out_m;
      if (clear_best_i) bv_m = 0;
      if (em_energy_valid_i && em_energy_ready_o) begin
        energy_pend = 0;
        exp_res_e = job_energy;
        exp_nb_m = !bv_m || (job_energy < be_m);
        if (exp_nb_m) begin
          bv_m = 1; be_m = job_energy; bid_m = exp_id;
        end
      end
      if (res_valid_o && res_ready_i) begin
        check(res_energy_o == exp_res_e, "res_energy", longint'($signed(res_energy_o)), longint'(exp_res_e));
        check(res_id_o == exp_id, "res_id", res_id_o, exp_id);
        check(res_new_best_o == exp_nb_m, "res_new_best", res_new_best_o, exp_nb_m);
        check(best_energy_o == be_m, "best_energy", longint'($signed(best_energy_o)), longint'(be_m));
        check(best_id_o == bid_m, "best_id", best_id_o, bid_m);
        last_nb = res_new_best_o;
        job_done = 1;
      end
    end
    prev_addr = mem_req_addr_o;
    prev_en = en_i;
  end

  task automatic start_job(input int start, input logic [IDB-1:0] id, input logic signed [EB-1:0] e,
                           input int lo, input int hi, input bit rnd, input bit hold);
    bit acc;
    lat_min = lo; lat_max = hi; rnd_ready = rnd; res_hold = hold;
    exp_start = start & ~(PAR - 1);
    exp_rows = (DS - exp_start) / PAR;
    exp_addr = exp_start / PAR;
    for (int i = 0; i < DS / 32; i++) exp_spin[i*32 +: 32] = $urandom();
    exp_id = id; job_energy = e;
    reqs_seen = 0; beats_seen = 0; max_out = 0; job_done = 0;
    @(posedge clk_i); #1;
    job_valid_i = 1'b1; job_spin_i = exp_spin; job_start_i = SB'(start); job_id_i = id;
    acc = 0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #2; acc = job_ready_o && en_i;
      @(posedge clk_i); #1;
    end
    job_valid_i = 1'b0;
    check(acc, "job_accept", acc, 1);
  endtask

  task automatic finish_job(input int rows_lit, input int nb_lit, input bit hold,
                            input logic signed [EB-1:0] e, input logic [IDB-1:0] id);
    bit seen;
    if (hold) begin
      seen = 0;
      for (int n = 0; n < 5000 && !seen; n++) begin
        @(posedge clk_i); #3; seen = res_valid_o;
      end
      check(seen, "hold_result_seen", seen, 1);
      for (int n = 0; n < 10; n++) begin
        check(res_valid_o && !job_ready_o && res_energy_o == e && res_id_o == id,
              "hold_stable", longint'($signed(res_energy_o)), longint'(e));
        @(posedge clk_i); #3;
      end
      res_hold = 0;
    end
    for (int n = 0; n < 5000 && !job_done; n++) begin
      @(posedge clk_i); #3;
    end
    check(job_done, "job_done", job_done, 1);
    check(reqs_seen == rows_lit, "req_count", reqs_seen, rows_lit);
    check(beats_seen == rows_lit, "beat_count", beats_seen, rows_lit);
    if (nb_lit >= 0) check(last_nb == 1'(nb_lit), "new_best_literal", last_nb, nb_lit);
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge clk_i);
    #2;
    check(job_ready_o == 1'b1, "reset_job_ready", job_ready_o, 1);
    check(others == '0, "reset_outputs_zero", others, 0);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #2;
    check(job_ready_o && !em_config_valid_o, "idle_hold", {job_ready_o, em_config_valid_o}, 2);

    stray = 1;
    @(posedge clk_i); #3;
    check(!em_weight_valid_o && !mem_rsp_ready_o, "stray_rsp_blocked",
          {em_weight_valid_o, mem_rsp_ready_o}, 0);
    stray = 0;

    start_job(0, 8'd1, -32'sd5, 3, 3, 0, 0);   finish_job(64, 1, 0, -32'sd5, 8'd1);
    start_job(200, 8'd2, 32'sd3, 3, 3, 0, 0);  finish_job(14, 0, 0, 32'sd3, 8'd2);
    start_job(0, 8'd3, -32'sd5, 1, 8, 1, 0);   finish_job(64, 0, 0, -32'sd5, 8'd3);
    start_job(130, 8'd4, -32'sd9, 1, 8, 1, 0); finish_job(32, 1, 0, -32'sd9, 8'd4);
    #1;
    check($signed(best_energy_o) == -9, "best_after_four", longint'($signed(best_energy_o)), -9);
    check(best_id_o == 8'd4, "best_id_after_four", best_id_o, 4);

    @(posedge clk_i); #1; clear_req = 1;
    @(posedge clk_i); #3; clear_req = 0;
    @(posedge clk_i); #3;
    check($signed(best_energy_o) == -9, "clear_keeps_value", longint'($signed(best_energy_o)), -9);
    start_job(252, 8'd5, 32'sd100, 3, 3, 0, 0); finish_job(1, 1, 0, 32'sd100, 8'd5);

    clear_on_energy = 1;
    start_job(0, 8'd6, 32'sd200, 2, 4, 0, 0);  finish_job(64, 1, 0, 32'sd200, 8'd6);
    clear_on_energy = 0;
    check($signed(best_energy_o) == 200 && best_id_o == 8'd6, "clear_priority_best",
          longint'($signed(best_energy_o)), 200);

    // async reset with two reads in flight
    start_job(0, 8'd7, 32'sd77, 8, 8, 0, 0);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk_i); #3; got = (out_m == 2);
    end
    check(got, "two_credits_out", out_m, 2);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check(job_ready_o == 1'b1, "midjob_reset_ready", job_ready_o, 1);
    check(others == '0, "midjob_reset_zero", others, 0);
    repeat (2) @(posedge clk_i);
    #1; rst_ni = 1'b1;

    start_job(240, 8'd8, 32'sd50, 8, 8, 0, 1); finish_job(4, 1, 1, 32'sd50, 8'd8);
    check(max_out == MAXO, "credits_fill_after_reset", max_out, MAXO);

    fork
      begin
        start_job(4, 8'd9, -32'sd3, 1, 8, 1, 0);
        finish_job(63, 1, 0, -32'sd3, 8'd9);
      end
      begin
        repeat (40) @(posedge clk_i);
        #1; en_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1; en_i = 1'b1;
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog_timeout actual=%0d required=%0d", cyc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
